room_occupancy_counter: RTL and testbench

// Tracks how many people are in the room using two IR beam sensors across the

---
 rtl/room_occupancy_counter.sv | 158 +++++++++++++++
 tb/tb_room_occupancy_counter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/room_occupancy_counter.sv
// Doorway occupancy counter: two synchronised, debounced IR beams feed a direction FSM.
// Raw edge to debounced edge is 2+DEBOUNCE_CYCLES clocks; events and count are registered one clock later. No backpressure.
module room_occupancy_counter #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int MAX_PEOPLE      = 31
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sensor_a,
    input  logic       sensor_b,
    input  logic       clr,
    output logic [4:0] people_count,
    output logic       entry_pulse,
    output logic       exit_pulse,
    output logic       room_empty,
    output logic       room_full
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A, LOCKOUT
    } state_t;

    // Bit 0 carries the outer beam (a), bit 1 the inner beam (b).
    logic [1:0]     meta_q, sync_q, db_q;
    logic [DBW-1:0] db_cnt_q [2];
    logic           a, b;

    state_t         state_q, state_d;
    logic [TOW-1:0] to_cnt_q, to_cnt_d;
    logic           entry_evt, exit_evt;
    logic [4:0]     count_q, count_d;
    logic           entry_q, exit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q      <= '0;
            sync_q      <= '0;
            db_q        <= '0;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
        end else begin
            meta_q <= {sensor_b, sensor_a};
            sync_q <= meta_q;
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    db_q[i]     <= sync_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign a = db_q[0];
    assign b = db_q[1];

    always_comb begin
        state_d   = state_q;
        entry_evt = 1'b0;
        exit_evt  = 1'b0;
        case (state_q)
            IDLE: begin
                if (a && !b)      state_d = IN_A;
                else if (!a && b) state_d = OUT_B;
                else if (a && b)  state_d = LOCKOUT;
            end
            IN_A: begin
                if (a && b)        state_d = IN_AB;
                else if (!a && !b) state_d = IDLE;
                else if (!a && b)  state_d = LOCKOUT;
            end
            IN_AB: begin
                if (!a && b)       state_d = IN_B;
                else if (a && !b)  state_d = IN_A;
                else if (!a && !b) state_d = IDLE;
            end
            IN_B: begin
                if (!a && !b) begin
                    state_d   = IDLE;
                    entry_evt = 1'b1;
                end else if (a && b) state_d = IN_AB;
                else if (a && !b)    state_d = LOCKOUT;
            end
            OUT_B: begin
                if (a && b)        state_d = OUT_BA;
                else if (!a && !b) state_d = IDLE;
                else if (a && !b)  state_d = LOCKOUT;
            end
            OUT_BA: begin
                if (a && !b)       state_d = OUT_A;
                else if (!a && b)  state_d = OUT_B;
                else if (!a && !b) state_d = IDLE;
            end
            OUT_A: begin
                if (!a && !b) begin
                    state_d  = IDLE;
                    exit_evt = 1'b1;
                end else if (a && b) state_d = OUT_BA;
                else if (!a && b)    state_d = LOCKOUT;
            end
            LOCKOUT: begin
                if (!a && !b) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A stalled sequence is abandoned even if it would have completed this cycle.
        if (state_q != IDLE && state_q != LOCKOUT &&
            to_cnt_q == TOW'(TIMEOUT_CYCLES - 1)) begin
            state_d   = LOCKOUT;
            entry_evt = 1'b0;
            exit_evt  = 1'b0;
        end
    end

    always_comb begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (state_d != state_q || state_q == IDLE || state_q == LOCKOUT)
            to_cnt_d = '0;
    end

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (entry_evt && count_q != 5'(MAX_PEOPLE))
            count_d = count_q + 1'b1;
        else if (exit_evt && count_q != 5'd0)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            to_cnt_q <= '0;
            count_q  <= '0;
            entry_q  <= 1'b0;
            exit_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            count_q  <= count_d;
            entry_q  <= entry_evt;
            exit_q   <= exit_evt;
        end
    end

    assign people_count = count_q;
    assign entry_pulse  = entry_q;
    assign exit_pulse   = exit_q;
    assign room_empty   = (count_q == 5'd0);
    assign room_full    = (count_q == 5'(MAX_PEOPLE));
endmodule

// File: tb/tb_room_occupancy_counter.sv
// Scoreboard bench for room_occupancy_counter: expected pulses are queued as stimulus completes a sequence.
module tb_room_occupancy_counter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sensor_a = 1'b0;
    logic       sensor_b = 1'b0;
    logic       clr = 1'b0;
    logic [4:0] people_count;
    logic       entry_pulse, exit_pulse, room_empty, room_full;

    typedef struct {
        logic is_entry;
        int   cnt;
    } ev_t;

    ev_t sb_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  n_pulses = 0;
    int  last_pulse_cyc = 0;
    int  model_cnt = 0;

    room_occupancy_counter #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (50),
        .MAX_PEOPLE     (31)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sensor_a    (sensor_a),
        .sensor_b    (sensor_b),
        .clr         (clr),
        .people_count(people_count),
        .entry_pulse (entry_pulse),
        .exit_pulse  (exit_pulse),
        .room_empty  (room_empty),
        .room_full   (room_full)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Every pulse cycle must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && (entry_pulse || exit_pulse)) begin
            ev_t e;
            n_pulses       = n_pulses + 1;
            last_pulse_cyc = cyc;
            checks         = checks + 1;
            if (sb_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_pulse: entry=%0b exit=%0b count=%0d at cycle %0d, none expected",
                         entry_pulse, exit_pulse, people_count, cyc);
            end else begin
                e = sb_q.pop_front();
                if (entry_pulse !== e.is_entry || exit_pulse !== !e.is_entry ||
                    people_count !== 5'(e.cnt)) begin
                    errors = errors + 1;
                    $display("FAIL pulse_match: entry=%0b exit=%0b count=%0d, expected entry=%0b exit=%0b count=%0d",
                             entry_pulse, exit_pulse, people_count, e.is_entry, !e.is_entry, e.cnt);
                end
            end
        end
    end

    task automatic drive(input logic a, input logic b, input int n);
        sensor_a = a;
        sensor_b = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        #1;
        checks = checks + 1;
        if (sb_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL %s: %0d expected pulses still pending after %0d cycles, required 0",
                     name, sb_q.size(), budget);
            sb_q.delete();
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string name);
        checks = checks + 1;
        if (people_count !== 5'(model_cnt) || room_empty !== (model_cnt == 0) ||
            room_full !== (model_cnt == 31)) begin
            errors = errors + 1;
            $display("FAIL %s: count=%0d empty=%0b full=%0b, expected count=%0d empty=%0b full=%0b",
                     name, people_count, room_empty, room_full, model_cnt, model_cnt == 0, model_cnt == 31);
        end
    endtask

    task automatic do_entry(input int hold, input logic with_clr);
        drive(1'b1, 1'b0, hold);
        drive(1'b1, 1'b1, hold);
        drive(1'b0, 1'b1, hold);
        if (with_clr) model_cnt = 0;
        else if (model_cnt < 31) model_cnt = model_cnt + 1;
        sb_q.push_back('{1'b1, model_cnt});
        clr = with_clr;
        drive(1'b0, 1'b0, 1);
        wait_drain("entry_pulse", 20);
        clr = 1'b0;
    endtask

    task automatic do_exit(input int hold);
        drive(1'b0, 1'b1, hold);
        drive(1'b1, 1'b1, hold);
        drive(1'b1, 1'b0, hold);
        if (model_cnt > 0) model_cnt = model_cnt - 1;
        sb_q.push_back('{1'b0, model_cnt});
        drive(1'b0, 1'b0, 1);
        wait_drain("exit_pulse", 20);
    endtask

    task automatic clear_count();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_cnt = 0;
        check_outputs("clr_count");
    endtask

    task automatic test_reset();
        #2;
        checks = checks + 1;
        if (people_count !== 5'd0 || entry_pulse !== 1'b0 || exit_pulse !== 1'b0 ||
            room_empty !== 1'b1 || room_full !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_values: count=%0d entry=%0b exit=%0b empty=%0b full=%0b, expected 0 0 0 1 0",
                     people_count, entry_pulse, exit_pulse, room_empty, room_full);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("post_reset");
    endtask

    task automatic test_entry();
        int p0, clear_cyc, lat;
        p0 = n_pulses;
        drive(1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 10);
        drive(1'b0, 1'b1, 10);
        model_cnt = 1;
        sb_q.push_back('{1'b1, 1});
        clear_cyc = cyc;
        drive(1'b0, 1'b0, 1);
        wait_drain("entry_basic", 20);
        lat = last_pulse_cyc - clear_cyc;
        checks = checks + 1;
        if (n_pulses - p0 != 1 || lat < 6 || lat > 7) begin
            errors = errors + 1;
            $display("FAIL entry_latency: pulses=%0d latency=%0d, expected 1 pulse at 6..7 cycles",
                     n_pulses - p0, lat);
        end
        check_outputs("entry_count");
    endtask

    task automatic test_exit();
        do_exit(10);
        check_outputs("exit_count");
    endtask

    task automatic test_backout();
        int p0;
        p0 = n_pulses;
        drive(1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 10);
        drive(1'b1, 1'b0, 10);
        drive(1'b0, 1'b0, 20);
        checks = checks + 1;
        if (n_pulses != p0) begin
            errors = errors + 1;
            $display("FAIL backout_pulses: got %0d pulses, expected 0", n_pulses - p0);
        end
        check_outputs("backout_count");
    endtask

    task automatic test_glitch();
        drive(1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 3);
        drive(1'b1, 1'b0, 10);
        // A crossed glitch would lock the FSM out if the debouncer let it through.
        drive(1'b0, 1'b1, 3);
        drive(1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 10);
        drive(1'b0, 1'b1, 10);
        model_cnt = model_cnt + 1;
        sb_q.push_back('{1'b1, model_cnt});
        drive(1'b0, 1'b0, 1);
        wait_drain("glitch_entry", 20);
        check_outputs("glitch_count");
    endtask

    task automatic test_saturation();
        int p0;
        clear_count();
        p0 = n_pulses;
        for (int i = 0; i < 32; i++) do_entry(8, 1'b0);
        checks = checks + 1;
        if (n_pulses - p0 != 32) begin
            errors = errors + 1;
            $display("FAIL sat_pulses: got %0d entry pulses, expected 32", n_pulses - p0);
        end
        check_outputs("sat_full");
        clear_count();
        do_exit(8);
        check_outputs("underflow_hold");
    endtask

    task automatic test_timeout();
        int p0;
        p0 = n_pulses;
        drive(1'b1, 1'b0, 80);
        drive(1'b1, 1'b1, 10);
        drive(1'b0, 1'b1, 10);
        drive(1'b0, 1'b0, 20);
        checks = checks + 1;
        if (n_pulses != p0) begin
            errors = errors + 1;
            $display("FAIL timeout_lockout: got %0d pulses, expected 0", n_pulses - p0);
        end
        // Each phase stays under the timeout even though the whole sequence exceeds it.
        do_entry(40, 1'b0);
        check_outputs("timeout_recover");
    endtask

    task automatic test_clr_event();
        clear_count();
        for (int i = 0; i < 5; i++) do_entry(8, 1'b0);
        check_outputs("count_five");
        do_entry(10, 1'b1);
        check_outputs("clr_wins");
    endtask

    task automatic test_reset_mid();
        int p0;
        do_entry(8, 1'b0);
        p0 = n_pulses;
        drive(1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 10);
        rst_n = 1'b0;
        #1;
        model_cnt = 0;
        checks = checks + 1;
        if (people_count !== 5'd0 || entry_pulse !== 1'b0 || exit_pulse !== 1'b0 ||
            room_empty !== 1'b1 || room_full !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_mid: count=%0d entry=%0b exit=%0b empty=%0b full=%0b, expected 0 0 0 1 0",
                     people_count, entry_pulse, exit_pulse, room_empty, room_full);
        end
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks = checks + 1;
        if (n_pulses != p0) begin
            errors = errors + 1;
            $display("FAIL reset_mid_pulse: got %0d pulses, expected 0", n_pulses - p0);
        end
        do_entry(8, 1'b0);
        check_outputs("after_reset_entry");
    endtask

    initial begin
        test_reset();
        test_entry();
        test_exit();
        test_backout();
        test_glitch();
        test_saturation();
        test_timeout();
        test_clr_event();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
